elapsed_ms_timer: RTL and testbench
===================================

Name: elapsed_ms_timer

Overview:
- Count-up millisecond timer, the counterpart to the countdown timer: it measures elapsed time between a start event and a stop event.
- Used for reaction-time and score measurement in the game datapath.
- Pulses result_valid once per measurement and holds the frozen result until the next start.
- Saturates at MAX_MS and flags overflow when the user never stops.

Parameters:
MAX_MS, 3000, saturation value of elapsed_ms in milliseconds.
CLKS_PER_MS, 50000, clk cycles per millisecond (50 MHz clock).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous reset, active-low (0 = reset).
start  input  1  single-cycle pulse; begin a new measurement.
stop  input  1  single-cycle pulse; end the current measurement.
elapsed_ms  output  $clog2(MAX_MS+1)  elapsed milliseconds; live while running, frozen otherwise.
running  output  1  high while in RUNNING.
result_valid  output  1  one-cycle pulse when a measurement completes (stop or overflow).
overflow  output  1  high in OVERFLOW state.

Behaviour:
- States: IDLE, RUNNING, STOPPED, OVERFLOW. Encoding is free; outputs decode from the state.
- Reset (reset==0 at a clk edge) overrides everything.
  - Next state is IDLE.
  - elapsed_ms=0, prescaler count=0, running=0, result_valid=0, overflow=0.
  - Reset mid-measurement discards the measurement and produces no result_valid.
- Prescaler count has width $clog2(CLKS_PER_MS).
  - Counts 0..CLKS_PER_MS-1 only in RUNNING.
  - Wraps to 0 and generates a ms tick when count==CLKS_PER_MS-1.
  - Held at its value in all other states.
- IDLE/STOPPED/OVERFLOW + start:
  - Next cycle: state=RUNNING, elapsed_ms=0, count=0, overflow=0.
  - stop in the same cycle is ignored (start wins).
- IDLE/STOPPED/OVERFLOW + stop alone: ignored, no change.
- RUNNING, ms tick, elapsed_ms<MAX_MS: elapsed_ms increments by 1.
- RUNNING, ms tick, elapsed_ms==MAX_MS:
  - Next state is OVERFLOW; elapsed_ms stays at MAX_MS.
  - overflow=1, result_valid pulses for 1 cycle.
- RUNNING + stop:
  - Next cycle: state=STOPPED, elapsed_ms frozen at its current value, result_valid=1 for exactly one cycle.
  - A ms tick coinciding with stop is dropped; the stop value is the pre-edge elapsed_ms.
- RUNNING + start (with or without stop): start is ignored; stop is still honoured.
- Precedence: stop over overflow. If stop and the overflow tick coincide, go to STOPPED with elapsed_ms=MAX_MS and overflow=0.
- Timing:
  - result_valid is registered and asserts the cycle after the triggering edge. It is never high for two consecutive cycles.
  - running is registered and rises the cycle after start.
  - The first increment occurs CLKS_PER_MS cycles after entry to RUNNING.
- Width: elapsed_ms never exceeds MAX_MS. MAX_MS itself must be representable, hence the +1 in $clog2.

Test Plan (CLKS_PER_MS=4, MAX_MS=10 unless noted):
1. Reset: hold reset=0 for 3 cycles with start=1 -> all outputs 0, state IDLE; release -> still IDLE, elapsed_ms=0.
2. Normal measurement: start pulse, wait 22 cycles, stop pulse -> running=1 throughout, elapsed_ms=5 at stop, result_valid high exactly 1 cycle, elapsed_ms held at 5 for 100 further cycles.
3. Overflow: start and never stop -> elapsed_ms climbs 0..10; on the 11th tick overflow=1, result_valid 1 cycle, elapsed_ms stays 10; a later stop produces no change.
4. Restart: from STOPPED (elapsed_ms=5) pulse start -> next cycle elapsed_ms=0, running=1; start pulses while running do not reset the count.
5. Simultaneous events:
   - start+stop in IDLE -> RUNNING.
   - start+stop in RUNNING -> STOPPED with one result_valid.
   - stop coincident with the overflow tick -> STOPPED, elapsed_ms=10, overflow=0.
6. Mid-run reset: reset=0 while elapsed_ms=7 -> IDLE, elapsed_ms=0, no result_valid; run with default parameters to check 50000 cycles per ms.

Source files
------------

// File: rtl/elapsed_ms_timer.sv
// elapsed_ms_timer: count-up millisecond stopwatch for reaction-time/score
// measurement. A start pulse begins a measurement, a stop pulse ends it.
// The result is frozen until the next start. A run that is never stopped
// saturates at MAX_MS and raises overflow.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous reset, active low
//   start        pulse: begin a new measurement (ignored while running)
//   stop         pulse: end the current measurement (wins over start/overflow)
//   elapsed_ms   elapsed milliseconds, live while running, frozen otherwise
//   running      high in RUNNING
//   result_valid one-cycle pulse when a measurement completes
//   overflow     high in OVERFLOW
module elapsed_ms_timer #(
  parameter int MAX_MS      = 3000,
  parameter int CLKS_PER_MS = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  output logic [$clog2(MAX_MS+1)-1:0]   elapsed_ms,
  output logic                          running,
  output logic                          result_valid,
  output logic                          overflow
);

  localparam int EW = $clog2(MAX_MS+1);
  // Keep the prescaler at least one bit wide even for CLKS_PER_MS==1.
  localparam int CW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  localparam logic [EW-1:0] MAX_V  = EW'(MAX_MS);
  localparam logic [EW-1:0] ONE_E  = EW'(1);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_MS-1);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUNNING  = 2'd1,
    STOPPED  = 2'd2,
    OVERFLOW = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [EW-1:0] elapsed, elapsed_n;
  logic [CW-1:0] count, count_n;
  logic          rv, rv_n;
  logic          tick;

  assign tick = (state == RUNNING) && (count == LAST_C);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      elapsed <= '0;
      count   <= '0;
      rv      <= 1'b0;
    end else begin
      state   <= state_n;
      elapsed <= elapsed_n;
      count   <= count_n;
      rv      <= rv_n;
    end
  end

  always_comb begin
    state_n   = state;
    elapsed_n = elapsed;
    count_n   = count;
    rv_n      = 1'b0;
    case (state)
      RUNNING: begin
        if (stop) begin
          // A tick landing on the stop edge is dropped: result is pre-edge value.
          state_n = STOPPED;
          rv_n    = 1'b1;
        end else begin
          count_n = tick ? '0 : count + ONE_C;
          if (tick) begin
            if (elapsed < MAX_V) begin
              elapsed_n = elapsed + ONE_E;
            end else begin
              state_n = OVERFLOW;
              rv_n    = 1'b1;
            end
          end
        end
      end
      default: begin
        // IDLE/STOPPED/OVERFLOW: start (re)arms, stop alone does nothing.
        if (start) begin
          state_n   = RUNNING;
          elapsed_n = '0;
          count_n   = '0;
        end
      end
    endcase
  end

  assign elapsed_ms   = elapsed;
  assign running      = (state == RUNNING);
  assign overflow     = (state == OVERFLOW);
  assign result_valid = rv;

endmodule

// File: tb/tb_elapsed_ms_timer.sv
module tb_elapsed_ms_timer;

  logic       clk = 1'b0;
  logic       reset, start, stop, start2, stop2;
  logic [3:0] elapsed_ms;
  logic       running, result_valid, overflow;
  logic [11:0] elapsed2;
  logic       running2, rv2, ovf2;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  elapsed_ms_timer #(.MAX_MS(10), .CLKS_PER_MS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .elapsed_ms(elapsed_ms), .running(running),
    .result_valid(result_valid), .overflow(overflow)
  );

  elapsed_ms_timer dut2 (
    .clk(clk), .reset(reset), .start(start2), .stop(stop2),
    .elapsed_ms(elapsed2), .running(running2),
    .result_valid(rv2), .overflow(ovf2)
  );

  // advance one edge; inputs driven and outputs sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input logic s, input logic p);
    start = s; stop = p;
    step();
    start = 0; stop = 0;
  endtask

  task automatic test_reset();
    reset = 0; start = 1; stop = 0;
    steps(3);
    chk("reset_elapsed", elapsed_ms, 0);
    chk("reset_running", running, 0);
    chk("reset_rv", result_valid, 0);
    chk("reset_ovf", overflow, 0);
    start = 0; reset = 1;
    step();
    chk("post_reset_elapsed", elapsed_ms, 0);
    chk("post_reset_running", running, 0);
  endtask

  task automatic test_normal();
    int bad = 0;
    pulse(1, 0);
    chk("norm_start_running", running, 1);
    chk("norm_start_elapsed", elapsed_ms, 0);
    for (int i = 1; i <= 22; i++) begin
      step();
      if (running !== 1'b1 || elapsed_ms !== 4'(i / 4)) bad++;
    end
    chk("norm_run_trace_errs", bad, 0);
    pulse(0, 1);
    chk("norm_stop_elapsed", elapsed_ms, 5);
    chk("norm_stop_rv", result_valid, 1);
    chk("norm_stop_running", running, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (result_valid !== 1'b0 || elapsed_ms !== 4'd5) bad++;
    end
    chk("norm_hold_errs", bad, 0);
  endtask

  task automatic test_restart();
    pulse(1, 0);
    chk("rst_elapsed0", elapsed_ms, 0);
    chk("rst_running", running, 1);
    steps(5);
    chk("rst_e5", elapsed_ms, 1);
    pulse(1, 0);   // start while running: ignored
    chk("rst_start_ign_e", elapsed_ms, 1);
    chk("rst_start_ign_r", running, 1);
    steps(2);
    chk("rst_tick_e8", elapsed_ms, 2);
    pulse(0, 1);
    chk("rst_stop_rv", result_valid, 1);
    chk("rst_stop_e", elapsed_ms, 2);
  endtask

  task automatic test_overflow();
    pulse(1, 0);
    steps(43);
    chk("ovf_pre_e", elapsed_ms, 10);
    chk("ovf_pre_flag", overflow, 0);
    chk("ovf_pre_rv", result_valid, 0);
    step();
    chk("ovf_flag", overflow, 1);
    chk("ovf_rv", result_valid, 1);
    chk("ovf_e", elapsed_ms, 10);
    chk("ovf_running", running, 0);
    step();
    chk("ovf_rv_once", result_valid, 0);
    pulse(0, 1);
    chk("ovf_stop_flag", overflow, 1);
    chk("ovf_stop_e", elapsed_ms, 10);
    chk("ovf_stop_rv", result_valid, 0);
  endtask

  task automatic test_simultaneous();
    reset = 0; step(); reset = 1;
    pulse(1, 1);
    chk("sim_idle_running", running, 1);
    chk("sim_idle_rv", result_valid, 0);
    steps(2);
    pulse(1, 1);
    chk("sim_run_running", running, 0);
    chk("sim_run_rv", result_valid, 1);
    step();
    chk("sim_run_rv_once", result_valid, 0);
    pulse(1, 0);
    steps(43);
    pulse(0, 1);   // stop lands on the overflow tick
    chk("sim_ovt_e", elapsed_ms, 10);
    chk("sim_ovt_flag", overflow, 0);
    chk("sim_ovt_rv", result_valid, 1);
    chk("sim_ovt_running", running, 0);
  endtask

  task automatic test_midrun_reset();
    int bad = 0;
    pulse(1, 0);
    steps(28);
    chk("mid_e7", elapsed_ms, 7);
    reset = 0; step();
    chk("mid_e", elapsed_ms, 0);
    chk("mid_running", running, 0);
    chk("mid_rv", result_valid, 0);
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (result_valid !== 1'b0 || running !== 1'b0) bad++;
    end
    chk("mid_after_errs", bad, 0);
  endtask

  task automatic test_default_params();
    start2 = 1; step(); start2 = 0;
    chk("def_running", running2, 1);
    steps(49999);
    chk("def_e_before", elapsed2, 0);
    step();
    chk("def_e_tick", elapsed2, 1);
    stop2 = 1; step(); stop2 = 0;
    chk("def_stop_rv", rv2, 1);
    chk("def_ovf", ovf2, 0);
  endtask

  initial begin
    reset = 0; start = 0; stop = 0; start2 = 0; stop2 = 0;
    #1;
    test_reset();
    test_normal();
    test_restart();
    test_overflow();
    test_simultaneous();
    test_midrun_reset();
    test_default_params();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
